prg_uart_loader: RTL and testbench
==================================

Name: prg_uart_loader

Overview:
- Hardware initiator for the program/debug memory port of the instruction and data memories; a drop-in alternative to the soft-processor monitor.
- Receives binary command frames over a UART (8N1) and translates them into prg_* write and read cycles on imem or dmem.
- Drives prg_mode and prg_rst into the CPU clock generator and reset logic, and returns ACK, NAK or read data over UART.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200).
- TIMEOUT_CLKS, 5000000, max idle clks between bytes of one frame before the frame is aborted.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- uart_rxd  in  1  serial in, idle high, asynchronous to clk
- uart_txd  out  1  serial out, idle high
- prg_mode  out  1  1 = memories owned by prg port, CPU clock paused
- prg_rst  out  1  CPU reset request
- prg_imem_clk  out  1  imem prg clock strobe
- prg_imem_we  out  1  imem write enable
- prg_imem_addr  out  32  imem address
- prg_imem_wd  out  32  imem write data
- prg_imem_rd  in  32  imem read data
- prg_dmem_clk, prg_dmem_we, prg_dmem_addr, prg_dmem_wd, prg_dmem_rd: same as the imem group, for dmem

Behaviour:
- Reset (sync, rst=1 at posedge):
  - uart_txd=1; prg_mode=0; prg_rst=0.
  - All prg_*_clk/we=0; prg_*_addr and prg_*_wd = 0.
  - FSM returns to IDLE; rx/tx shifters are cleared.
  - A reset mid-frame or mid-reply aborts with no reply; a partially sent byte is truncated and the line returns high.
- UART RX:
  - uart_rxd passes through a 2-flop synchronizer.
  - A falling edge starts a bit timer. The start bit is re-checked at CLKS_PER_BIT/2; if the line is high, the start is treated as a glitch and ignored.
  - Data bits are sampled LSB first at bit centres.
  - Stop bit = 0 is a framing error: the byte is dropped and the frame continues as if it had not arrived.
- UART TX: LSB first, 1 start bit, 1 stop bit. Back-to-back reply bytes are sent with no idle gap.
- Frames (multi-byte fields big-endian):
  - 0x57 'W', tgt, a3..a0, d3..d0: write; reply 0x06.
  - 0x52 'R', tgt, a3..a0: read; reply d3..d0.
  - 0x4D 'M', arg: prg_mode <= arg[0], prg_rst <= arg[1], both update at the cycle the arg byte completes; reply 0x06.
  - tgt 0x00 = imem, 0x01 = dmem. Any other tgt: the full frame is still consumed, then reply 0x15 (NAK) with no memory cycle.
  - Unknown opcode: reply 0x15 immediately and return to IDLE.
- W and R are accepted regardless of prg_mode; the host is responsible for setting mode first.
- FSM states: IDLE, GET_TGT, GET_ADDR(4), GET_DATA(4), GET_ARG, MEM_SETUP, MEM_CLK_HI, MEM_CLK_LO, CAPTURE, REPLY.
- Memory cycle:
  - Relative to MEM_SETUP (cycle 0), for the selected target only:
    - c0: addr/wd/we valid (we=1 for W only)
    - c1: clk=1
    - c2: clk=0, we=0
    - c3 (R only): prg_*_rd is captured into the reply register
  - addr/wd then hold their values until the next frame.
  - The unselected target's clk and we stay 0.
- Inter-byte timeout: if a frame has started and more than TIMEOUT_CLKS clks pass without a byte, return to IDLE with no reply and no memory cycle.
- Busy: bytes that complete while the FSM is in memory-cycle or REPLY states are discarded. The host waits for the full reply before sending the next frame.
- The 32-bit address and data are passed through unmodified; word vs byte addressing is the memories' concern.

Test Plan:
Benches use CLKS_PER_BIT=8 and TIMEOUT_CLKS=2000.
- After rst, send 4D 01 -> prg_mode=1, prg_rst=0, uart_txd returns 06.
- Send 57 00 00000004 DEADBEEF -> a single prg_imem_clk high pulse with addr=0x4, wd=0xDEADBEEF, we=1; dmem clk/we stay 0; reply 06.
- Model dmem returning 0x12345678 at addr 0x10; send 52 01 00000010 -> one prg_dmem_clk pulse, we=0; reply bytes 12 34 56 78 in order.
- Send 57 05 ... (bad tgt, 10 bytes total) -> no clk pulses, reply 15. Send single byte 0xAA -> reply 15.
- Send 57 00 00, then idle 2100 clks, then 4D 03 -> no reply to the partial frame; prg_mode=1, prg_rst=1, reply 06.
- Start bit glitch of 2 clks -> no byte received. Byte with stop bit=0 inside a 4D frame -> ignored, frame still completes on the next valid byte. Assert rst mid-reply -> uart_txd=1 the next cycle and all outputs at reset values.

Source files
------------

// File: rtl/prg_uart_loader.sv
// UART-driven initiator for the imem/dmem program port: decodes W/R/M command frames,
// runs one prg_* memory cycle per frame and sends back ACK, NAK or read data.
module prg_uart_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_CLKS = 5000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rxd,
    output logic        uart_txd,
    output logic        prg_mode,
    output logic        prg_rst,
    output logic        prg_imem_clk,
    output logic        prg_imem_we,
    output logic [31:0] prg_imem_addr,
    output logic [31:0] prg_imem_wd,
    input  logic [31:0] prg_imem_rd,
    output logic        prg_dmem_clk,
    output logic        prg_dmem_we,
    output logic [31:0] prg_dmem_addr,
    output logic [31:0] prg_dmem_wd,
    input  logic [31:0] prg_dmem_rd
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CLKS);
    localparam logic [7:0] ACK  = 8'h06;
    localparam logic [7:0] NAK  = 8'h15;
    localparam logic [7:0] OP_W = 8'h57;
    localparam logic [7:0] OP_R = 8'h52;
    localparam logic [7:0] OP_M = 8'h4D;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [3:0] {
        IDLE, GET_TGT, GET_ADDR, GET_DATA, GET_ARG,
        MEM_SETUP, MEM_CLK_HI, MEM_CLK_LO, CAPTURE, REPLY
    } state_t;

    logic             rxd_meta_r, rxd_sync_r, rxd_prev_r;
    rx_state_t        rx_state_r;
    logic [CNT_W-1:0] rx_cnt_r;
    logic [2:0]       rx_bit_r;
    logic [7:0]       rx_shift_r, rx_byte_r;
    logic             rx_valid_r;

    logic [9:0]       tx_shift_r;
    logic             tx_active_r;
    logic [CNT_W-1:0] tx_cnt_r;
    logic [3:0]       tx_bit_r;
    logic [2:0]       tx_left_r;
    logic [31:0]      tx_buf_r;

    state_t      state_r;
    logic [1:0]  idx_r;
    logic        is_write_r;
    logic [7:0]  tgt_r;
    logic [31:0] addr_r, data_r, timer_r, reply_r;
    logic [2:0]  reply_len_r;
    logic        tx_req_r;

    logic [31:0] addr_next_s, data_next_s, mem_addr_s;
    logic        tgt_ok_s, in_frame_s, timeout_s;

    assign addr_next_s = {addr_r[23:0], rx_byte_r};
    assign data_next_s = {data_r[23:0], rx_byte_r};
    // A read frame ends on its last address byte, so that byte is not yet in addr_r.
    assign mem_addr_s  = is_write_r ? addr_r : addr_next_s;
    assign tgt_ok_s    = (tgt_r[7:1] == 7'd0);
    assign in_frame_s  = (state_r == GET_TGT) || (state_r == GET_ADDR) ||
                         (state_r == GET_DATA) || (state_r == GET_ARG);
    assign timeout_s   = (timer_r >= TIMEOUT_LIM);
    assign uart_txd    = tx_shift_r[0];

    // Synchronise uart_rxd and deserialise 8N1 bytes, dropping glitches and framing errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta_r <= 1'b1;
            rxd_sync_r <= 1'b1;
            rxd_prev_r <= 1'b1;
            rx_state_r <= RX_IDLE;
            rx_cnt_r   <= '0;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'h00;
            rx_byte_r  <= 8'h00;
            rx_valid_r <= 1'b0;
        end else begin
            rxd_meta_r <= uart_rxd;
            rxd_sync_r <= rxd_meta_r;
            rxd_prev_r <= rxd_sync_r;
            rx_valid_r <= 1'b0;
            case (rx_state_r)
                RX_IDLE: begin
                    rx_cnt_r <= '0;
                    rx_bit_r <= 3'd0;
                    if (rxd_prev_r && !rxd_sync_r) rx_state_r <= RX_START;
                end
                RX_START: begin
                    if (rx_cnt_r == HALF_LAST) begin
                        rx_cnt_r   <= '0;
                        rx_state_r <= rxd_sync_r ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_r <= rx_cnt_r + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_r == BIT_LAST) begin
                        rx_cnt_r   <= '0;
                        rx_shift_r <= {rxd_sync_r, rx_shift_r[7:1]};
                        rx_bit_r   <= rx_bit_r + 3'd1;
                        if (rx_bit_r == 3'd7) rx_state_r <= RX_STOP;
                    end else begin
                        rx_cnt_r <= rx_cnt_r + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_r == BIT_LAST) begin
                        rx_cnt_r   <= '0;
                        rx_state_r <= RX_IDLE;
                        if (rxd_sync_r) begin
                            rx_valid_r <= 1'b1;
                            rx_byte_r  <= rx_shift_r;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r + 1'b1;
                    end
                end
                default: rx_state_r <= RX_IDLE;
            endcase
        end
    end

    // Serialise a 1- or 4-byte reply MSB-byte first; the next byte loads in the stop bit's last clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_shift_r  <= 10'h3FF;
            tx_active_r <= 1'b0;
            tx_cnt_r    <= '0;
            tx_bit_r    <= 4'd0;
            tx_left_r   <= 3'd0;
            tx_buf_r    <= 32'h0;
        end else if (!tx_active_r) begin
            if (tx_req_r) begin
                tx_shift_r  <= {1'b1, reply_r[31:24], 1'b0};
                tx_buf_r    <= {reply_r[23:0], 8'h00};
                tx_left_r   <= reply_len_r - 3'd1;
                tx_active_r <= 1'b1;
                tx_cnt_r    <= '0;
                tx_bit_r    <= 4'd0;
            end
        end else if (tx_cnt_r != BIT_LAST) begin
            tx_cnt_r <= tx_cnt_r + 1'b1;
        end else begin
            tx_cnt_r <= '0;
            if (tx_bit_r != 4'd9) begin
                tx_shift_r <= {1'b1, tx_shift_r[9:1]};
                tx_bit_r   <= tx_bit_r + 4'd1;
            end else if (tx_left_r != 3'd0) begin
                tx_shift_r <= {1'b1, tx_buf_r[31:24], 1'b0};
                tx_buf_r   <= {tx_buf_r[23:0], 8'h00};
                tx_left_r  <= tx_left_r - 3'd1;
                tx_bit_r   <= 4'd0;
            end else begin
                tx_active_r <= 1'b0;
                tx_shift_r  <= 10'h3FF;
                tx_bit_r    <= 4'd0;
            end
        end
    end

    // Frame decoder, memory-cycle sequencer and reply launcher.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            idx_r         <= 2'd0;
            is_write_r    <= 1'b0;
            tgt_r         <= 8'h00;
            addr_r        <= 32'h0;
            data_r        <= 32'h0;
            timer_r       <= 32'h0;
            reply_r       <= 32'h0;
            reply_len_r   <= 3'd0;
            tx_req_r      <= 1'b0;
            prg_mode      <= 1'b0;
            prg_rst       <= 1'b0;
            prg_imem_clk  <= 1'b0;
            prg_imem_we   <= 1'b0;
            prg_imem_addr <= 32'h0;
            prg_imem_wd   <= 32'h0;
            prg_dmem_clk  <= 1'b0;
            prg_dmem_we   <= 1'b0;
            prg_dmem_addr <= 32'h0;
            prg_dmem_wd   <= 32'h0;
        end else begin
            tx_req_r <= 1'b0;
            if (in_frame_s && !rx_valid_r) timer_r <= timer_r + 32'd1;
            else                           timer_r <= 32'h0;
            case (state_r)
                IDLE: begin
                    idx_r <= 2'd0;
                    if (rx_valid_r) begin
                        case (rx_byte_r)
                            OP_W: begin is_write_r <= 1'b1; state_r <= GET_TGT; end
                            OP_R: begin is_write_r <= 1'b0; state_r <= GET_TGT; end
                            OP_M: state_r <= GET_ARG;
                            default: begin
                                reply_r     <= {NAK, 24'h0};
                                reply_len_r <= 3'd1;
                                tx_req_r    <= 1'b1;
                                state_r     <= REPLY;
                            end
                        endcase
                    end
                end
                GET_TGT: begin
                    if (timeout_s) begin
                        state_r <= IDLE;
                    end else if (rx_valid_r) begin
                        tgt_r   <= rx_byte_r;
                        idx_r   <= 2'd0;
                        state_r <= GET_ADDR;
                    end
                end
                GET_ADDR, GET_DATA: begin
                    if (timeout_s) begin
                        state_r <= IDLE;
                    end else if (rx_valid_r) begin
                        if (state_r == GET_ADDR) addr_r <= addr_next_s;
                        else                     data_r <= data_next_s;
                        idx_r <= idx_r + 2'd1;
                        if (idx_r == 2'd3) begin
                            if (state_r == GET_ADDR && is_write_r) begin
                                state_r <= GET_DATA;
                            end else if (!tgt_ok_s) begin
                                reply_r     <= {NAK, 24'h0};
                                reply_len_r <= 3'd1;
                                tx_req_r    <= 1'b1;
                                state_r     <= REPLY;
                            end else begin
                                if (tgt_r[0]) begin
                                    prg_dmem_addr <= mem_addr_s;
                                    prg_dmem_we   <= is_write_r;
                                    if (is_write_r) prg_dmem_wd <= data_next_s;
                                end else begin
                                    prg_imem_addr <= mem_addr_s;
                                    prg_imem_we   <= is_write_r;
                                    if (is_write_r) prg_imem_wd <= data_next_s;
                                end
                                state_r <= MEM_SETUP;
                            end
                        end
                    end
                end
                GET_ARG: begin
                    if (timeout_s) begin
                        state_r <= IDLE;
                    end else if (rx_valid_r) begin
                        prg_mode    <= rx_byte_r[0];
                        prg_rst     <= rx_byte_r[1];
                        reply_r     <= {ACK, 24'h0};
                        reply_len_r <= 3'd1;
                        tx_req_r    <= 1'b1;
                        state_r     <= REPLY;
                    end
                end
                MEM_SETUP: begin
                    if (tgt_r[0]) prg_dmem_clk <= 1'b1;
                    else          prg_imem_clk <= 1'b1;
                    state_r <= MEM_CLK_HI;
                end
                MEM_CLK_HI: begin
                    prg_imem_clk <= 1'b0;
                    prg_dmem_clk <= 1'b0;
                    prg_imem_we  <= 1'b0;
                    prg_dmem_we  <= 1'b0;
                    state_r      <= MEM_CLK_LO;
                end
                MEM_CLK_LO: begin
                    if (is_write_r) begin
                        reply_r     <= {ACK, 24'h0};
                        reply_len_r <= 3'd1;
                        tx_req_r    <= 1'b1;
                        state_r     <= REPLY;
                    end else begin
                        state_r <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    reply_r     <= tgt_r[0] ? prg_dmem_rd : prg_imem_rd;
                    reply_len_r <= 3'd4;
                    tx_req_r    <= 1'b1;
                    state_r     <= REPLY;
                end
                REPLY: begin
                    if (!tx_req_r && !tx_active_r) state_r <= IDLE;
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prg_uart_loader.sv
// Directed bench for prg_uart_loader: drives 8N1 frames into uart_rxd, decodes uart_txd replies
// and watches prg_* strobes against hand-computed expectations.
module tb_prg_uart_loader;

    localparam int CPB = 8;

    logic        clk, rst, uart_rxd;
    logic        uart_txd, prg_mode, prg_rst;
    logic        prg_imem_clk, prg_imem_we, prg_dmem_clk, prg_dmem_we;
    logic [31:0] prg_imem_addr, prg_imem_wd, prg_imem_rd;
    logic [31:0] prg_dmem_addr, prg_dmem_wd, prg_dmem_rd;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] rx_q[$];
    int          imem_pulses = 0, dmem_pulses = 0;
    logic [31:0] imem_cap_addr, imem_cap_wd, dmem_cap_addr;
    logic        imem_cap_we, dmem_cap_we;

    prg_uart_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(2000)) dut (
        .clk(clk), .rst(rst), .uart_rxd(uart_rxd), .uart_txd(uart_txd),
        .prg_mode(prg_mode), .prg_rst(prg_rst),
        .prg_imem_clk(prg_imem_clk), .prg_imem_we(prg_imem_we),
        .prg_imem_addr(prg_imem_addr), .prg_imem_wd(prg_imem_wd), .prg_imem_rd(prg_imem_rd),
        .prg_dmem_clk(prg_dmem_clk), .prg_dmem_we(prg_dmem_we),
        .prg_dmem_addr(prg_dmem_addr), .prg_dmem_wd(prg_dmem_wd), .prg_dmem_rd(prg_dmem_rd)
    );

    assign prg_imem_rd = 32'hCAFEF00D;
    assign prg_dmem_rd = (prg_dmem_addr == 32'h10) ? 32'h12345678 : 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            tick(CPB);
        end
        uart_rxd = stop_bit;
        tick(CPB);
        uart_rxd = 1'b1;
        tick(2);
    endtask

    // Waits (bounded) for n reply bytes, lets any stray extra byte arrive, then checks count and values.
    task automatic expect_bytes(input string tag, input int n, input logic [31:0] exp_word);
        int waited = 0;
        logic [7:0] b;
        while (rx_q.size() < n && waited < 3000) begin
            tick(1);
            waited++;
        end
        tick(150);
        check({tag, "_count"}, 32'(rx_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (rx_q.size() > 0) begin
                b = rx_q.pop_front();
                check({tag, "_byte"}, {24'h0, b}, {24'h0, exp_word[8*(n-1-i) +: 8]});
            end
        end
        rx_q.delete();
    endtask

    // UART receiver model for uart_txd, sampling bit centres on the falling clock edge.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (uart_txd === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = uart_txd;
                end
                repeat (CPB) @(negedge clk);
                rx_q.push_back(b);
            end
        end
    end

    // Counts prg clock rising edges and captures the bus at each one.
    initial begin
        logic ip, dp;
        ip = 1'b0;
        dp = 1'b0;
        forever begin
            @(negedge clk);
            if (prg_imem_clk === 1'b1 && !ip) begin
                imem_pulses++;
                imem_cap_addr = prg_imem_addr;
                imem_cap_wd   = prg_imem_wd;
                imem_cap_we   = prg_imem_we;
            end
            if (prg_dmem_clk === 1'b1 && !dp) begin
                dmem_pulses++;
                dmem_cap_addr = prg_dmem_addr;
                dmem_cap_we   = prg_dmem_we;
            end
            ip = (prg_imem_clk === 1'b1);
            dp = (prg_dmem_clk === 1'b1);
        end
    end

    initial begin
        int ib, db, w, lows;
        rst = 1'b1;
        uart_rxd = 1'b1;
        tick(4);
        check("rst_txd", {31'h0, uart_txd}, 32'h1);
        check("rst_mode", {31'h0, prg_mode}, 32'h0);
        check("rst_prg_rst", {31'h0, prg_rst}, 32'h0);
        check("rst_strobes", {28'h0, prg_imem_clk, prg_imem_we, prg_dmem_clk, prg_dmem_we}, 32'h0);
        check("rst_imem_addr", prg_imem_addr, 32'h0);
        check("rst_dmem_wd", prg_dmem_wd, 32'h0);
        rst = 1'b0;
        tick(10);

        // Mode command
        send_byte(8'h4D, 1'b1); send_byte(8'h01, 1'b1);
        expect_bytes("m01", 1, 32'h06);
        check("m01_mode", {31'h0, prg_mode}, 32'h1);
        check("m01_prg_rst", {31'h0, prg_rst}, 32'h0);

        // imem write
        ib = imem_pulses; db = dmem_pulses;
        send_byte(8'h57, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h04, 1'b1);
        send_byte(8'hDE, 1'b1); send_byte(8'hAD, 1'b1); send_byte(8'hBE, 1'b1); send_byte(8'hEF, 1'b1);
        expect_bytes("wr", 1, 32'h06);
        check("wr_imem_pulses", 32'(imem_pulses - ib), 32'd1);
        check("wr_dmem_pulses", 32'(dmem_pulses - db), 32'd0);
        check("wr_addr", imem_cap_addr, 32'h4);
        check("wr_wd", imem_cap_wd, 32'hDEADBEEF);
        check("wr_we_at_clk", {31'h0, imem_cap_we}, 32'h1);
        check("wr_we_after", {31'h0, prg_imem_we}, 32'h0);
        check("wr_addr_hold", prg_imem_addr, 32'h4);

        // dmem read
        ib = imem_pulses; db = dmem_pulses;
        send_byte(8'h52, 1'b1); send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h10, 1'b1);
        expect_bytes("rd", 4, 32'h12345678);
        check("rd_dmem_pulses", 32'(dmem_pulses - db), 32'd1);
        check("rd_imem_pulses", 32'(imem_pulses - ib), 32'd0);
        check("rd_addr", dmem_cap_addr, 32'h10);
        check("rd_we_at_clk", {31'h0, dmem_cap_we}, 32'h0);

        // Bad target: full frame consumed, NAK, no memory cycle
        ib = imem_pulses; db = dmem_pulses;
        send_byte(8'h57, 1'b1); send_byte(8'h05, 1'b1);
        send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h08, 1'b1);
        send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1); send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
        expect_bytes("badtgt", 1, 32'h15);
        check("badtgt_pulses", 32'((imem_pulses - ib) + (dmem_pulses - db)), 32'd0);

        // Unknown opcode
        send_byte(8'hAA, 1'b1);
        expect_bytes("badop", 1, 32'h15);

        // Inter-byte timeout drops the partial frame silently
        send_byte(8'h57, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
        tick(2100);
        check("timeout_silent", 32'(rx_q.size()), 32'd0);
        send_byte(8'h4D, 1'b1); send_byte(8'h03, 1'b1);
        expect_bytes("m03", 1, 32'h06);
        check("m03_mode", {31'h0, prg_mode}, 32'h1);
        check("m03_prg_rst", {31'h0, prg_rst}, 32'h1);

        // Two-clock start glitch must not produce a byte
        uart_rxd = 1'b0;
        tick(2);
        uart_rxd = 1'b1;
        tick(200);
        check("glitch_silent", 32'(rx_q.size()), 32'd0);

        // Framing error inside an M frame: bad byte ignored, next byte is the arg
        send_byte(8'h4D, 1'b1); send_byte(8'h02, 1'b0); send_byte(8'h01, 1'b1);
        expect_bytes("ferr", 1, 32'h06);
        check("ferr_mode", {31'h0, prg_mode}, 32'h1);
        check("ferr_prg_rst", {31'h0, prg_rst}, 32'h0);

        // Reset in the middle of a 4-byte read reply
        send_byte(8'h52, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
        w = 0;
        while (uart_txd && w < 500) begin
            tick(1);
            w++;
        end
        check("midrst_reply_started", {31'h0, uart_txd}, 32'h0);
        tick(20);
        rst = 1'b1;
        tick(1);
        check("midrst_txd", {31'h0, uart_txd}, 32'h1);
        check("midrst_mode", {31'h0, prg_mode}, 32'h0);
        check("midrst_dmem_addr", prg_dmem_addr, 32'h0);
        check("midrst_imem_wd", prg_imem_wd, 32'h0);
        tick(2);
        rst = 1'b0;
        lows = 0;
        repeat (300) begin
            tick(1);
            if (uart_txd !== 1'b1) lows++;
        end
        check("midrst_line_idle", 32'(lows), 32'd0);
        rx_q.delete();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
